// File: rtl/vred_logic_tree_pkg.sv
// Shared vALU reduction definitions: opSel encodings, per-bit identity and combine helpers.
// Helpers work on single bits so any DATA_WIDTH can apply them lane by lane.
package vred_logic_tree_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } in_state_e;

    // Identity bit of an op: ones for AND, zero for OR/XOR (and for the invalid op).
    function automatic logic identity_bit(input logic [1:0] op);
        return (op == OP_AND);
    endfunction

    function automatic logic combine_bit(input logic [1:0] op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vred_logic_tree_stage.sv
// One registered level of the reduction tree: combines adjacent lane pairs and
// carries the beat sideband along; data and sideband hold while the level is idle.
module vred_logic_stage
    import vred_logic_tree_pkg::*;
#(
    parameter int PAIRS       = 1,
    parameter int DATA_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [OPSEL_WIDTH-1:0]          in_op,
    input  logic [DATA_WIDTH-1:0]           in_scalar,
    input  logic [2*PAIRS*DATA_WIDTH-1:0]   in_data,
    output logic                            out_valid,
    output logic                            out_first,
    output logic                            out_last,
    output logic [OPSEL_WIDTH-1:0]          out_op,
    output logic [DATA_WIDTH-1:0]           out_scalar,
    output logic [PAIRS*DATA_WIDTH-1:0]     out_data
);

    logic [PAIRS*DATA_WIDTH-1:0] pair_data;

    always_comb begin
        pair_data = '0;
        for (int p = 0; p < PAIRS; p++) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                pair_data[p*DATA_WIDTH + b] = combine_bit(in_op,
                    in_data[(2*p)*DATA_WIDTH + b], in_data[(2*p+1)*DATA_WIDTH + b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_op     <= '0;
            out_scalar <= '0;
            out_data   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_first  <= in_first;
                out_last   <= in_last;
                out_op     <= in_op;
                out_scalar <= in_scalar;
                out_data   <= pair_data;
            end
        end
    end

endmodule

// File: rtl/vred_logic_tree.sv
// Pipelined vredand/vredor/vredxor: log2(LANES) registered tree levels plus an accumulator.
// Optional lane masking is compiled in with VRED_MASK_EN.
module vred_logic_tree
    import vred_logic_tree_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [LANES*DATA_WIDTH-1:0]   in_vec,
    input  logic [LANES-1:0]              in_mask,
    input  logic [OPSEL_WIDTH-1:0]        in_opSel,
    input  logic [DATA_WIDTH-1:0]         in_scalar,
    input  logic                          in_last,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_vec,
    output logic                          out_busy
);

    localparam int STAGES = $clog2(LANES);
    localparam int DW     = DATA_WIDTH;
    // All tree levels packed back to back: level k starts at (2*LANES - 2*(LANES>>k))*DW.
    localparam int TOTAL  = (2*LANES - 1) * DW;

    in_state_e state_q, state_d;
    logic [OPSEL_WIDTH-1:0] op_q;
    logic [DW-1:0]          scalar_q;
    logic                   beat_first;
    logic [OPSEL_WIDTH-1:0] beat_op;
    logic [DW-1:0]          beat_scalar;
    logic [LANES*DW-1:0]    lane_data;

    logic [TOTAL-1:0]       tree_data;
    logic                   tree_valid  [0:STAGES];
    logic                   tree_first  [0:STAGES];
    logic                   tree_last   [0:STAGES];
    logic [OPSEL_WIDTH-1:0] tree_op     [0:STAGES];
    logic [DW-1:0]          tree_scalar [0:STAGES];

    logic [DW-1:0]          root_data;
    logic [DW-1:0]          acc_q, acc_next;
    logic                   stages_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            scalar_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                op_q     <= in_opSel;
                scalar_q <= in_scalar;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid && !in_last) state_d = ST_OPEN;
            ST_OPEN: if (in_valid && in_last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign beat_first  = (state_q == ST_IDLE);
    assign beat_op     = beat_first ? in_opSel  : op_q;
    assign beat_scalar = beat_first ? in_scalar : scalar_q;

`ifdef VRED_MASK_EN
    always_comb begin
        lane_data = in_vec;
        for (int i = 0; i < LANES; i++) begin
            if (!in_mask[i]) lane_data[i*DW +: DW] = {DW{identity_bit(beat_op)}};
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^in_mask;
    assign lane_data   = in_vec;
`endif

    assign tree_data[LANES*DW-1:0] = lane_data;
    assign tree_valid[0]  = in_valid;
    assign tree_first[0]  = beat_first;
    assign tree_last[0]   = in_last;
    assign tree_op[0]     = beat_op;
    assign tree_scalar[0] = beat_scalar;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam int PAIRS   = LANES >> k;
        localparam int IN_OFF  = (2*LANES - 2*(LANES >> (k-1))) * DW;
        localparam int OUT_OFF = (2*LANES - 2*PAIRS) * DW;

        vred_logic_stage #(
            .PAIRS      (PAIRS),
            .DATA_WIDTH (DW),
            .OPSEL_WIDTH(OPSEL_WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (tree_valid[k-1]),
            .in_first  (tree_first[k-1]),
            .in_last   (tree_last[k-1]),
            .in_op     (tree_op[k-1]),
            .in_scalar (tree_scalar[k-1]),
            .in_data   (tree_data[IN_OFF +: 2*PAIRS*DW]),
            .out_valid (tree_valid[k]),
            .out_first (tree_first[k]),
            .out_last  (tree_last[k]),
            .out_op    (tree_op[k]),
            .out_scalar(tree_scalar[k]),
            .out_data  (tree_data[OUT_OFF +: PAIRS*DW])
        );
    end

    assign root_data = tree_data[TOTAL-1 -: DW];

    // A first-tagged beat seeds from its own scalar, so a stale accumulator never leaks in.
    always_comb begin
        acc_next = '0;
        for (int b = 0; b < DW; b++) begin
            acc_next[b] = combine_bit(tree_op[STAGES],
                tree_first[STAGES] ? tree_scalar[STAGES][b] : acc_q[b], root_data[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (tree_valid[STAGES]) begin
                acc_q <= acc_next;
                if (tree_last[STAGES]) begin
                    out_vec   <= acc_next;
                    out_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        stages_busy = 1'b0;
        for (int k = 1; k <= STAGES; k++) stages_busy = stages_busy | tree_valid[k];
    end

    assign out_busy = (state_q == ST_OPEN) | stages_busy;

endmodule

// File: doc/vred_logic_tree.md
Name: vred_logic_tree

Overview:
- Pipelined, parametrised successor to the two-operand AND/OR/XOR reduction step.
- Reduces LANES elements per beat through a registered binary tree of log2(LANES) stages.
- Folds multiple beats into an accumulator seeded with the scalar operand (vs1[0]).
- Sits in the vALU reduction path and produces one scalar result per vredand/vredor/vredxor instruction.

Parameters:
- LANES, 8, elements per beat; power of two, >=2.
- DATA_WIDTH, 32, element width in bits.
- OPSEL_WIDTH, 2, opcode width; 01=and, 10=or, 11=xor, 00=invalid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  beat valid; no backpressure, every valid beat is accepted.
- in_vec  in  LANES*DATA_WIDTH  lane data; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_mask  in  LANES  per-lane enable; used only with VRED_MASK_EN.
- in_opSel  in  OPSEL_WIDTH  operation; sampled on the first beat only.
- in_scalar  in  DATA_WIDTH  seed (vs1[0]); sampled on the first beat only.
- in_last  in  1  final beat of the reduction.
- out_valid  out  1  one-cycle pulse; result valid.
- out_vec  out  DATA_WIDTH  reduction result.
- out_busy  out  1  high while any beat is in the pipeline or a reduction is open.

Behaviour:
- Reset values: out_valid=0, out_vec=0, out_busy=0, accumulator=0, all stage valids=0, input FSM=IDLE.
- Input FSM has two states, IDLE and OPEN.
  - IDLE: an accepted beat is tagged first=1, and opSel and scalar are captured.
  - IDLE -> OPEN on in_valid & !in_last.
  - OPEN -> IDLE on in_valid & in_last.
  - Single-beat reduction (in_last on the first beat) stays in IDLE.
  - Beats accepted in OPEN are tagged first=0 and use the captured opSel/scalar. in_opSel/in_scalar are ignored in OPEN.
- Tree:
  - Stage k combines adjacent pairs from stage k-1 and registers them, for k=1..log2(LANES).
  - Each stage register carries the sideband {valid, first, last, opSel, scalar}.
  - Invalid stages hold their data; only valid advances.
- Accumulate stage, one register after the tree root, acting when the root is valid:
  - if first, acc_next = scalar OP root; else acc_next = acc OP root.
  - acc <= acc_next.
  - if last, out_vec <= acc_next and out_valid <= 1.
- Latency: a beat with in_last at cycle t gives out_valid at t+log2(LANES)+1.
  - Example: LANES=8 gives 4 cycles.
- Throughput: one beat per cycle. Back-to-back reductions need no bubble, because the first tag overrides the stale accumulator.
- opSel=00: every combine yields 0, so the result is 0. This is not an error.
- out_vec holds its value between results; out_valid is high for exactly one cycle per in_last beat.
- out_busy = (FSM==OPEN) | OR of all stage valids.
- rst mid-reduction: the pipeline is flushed, the partial result is discarded, no out_valid is produced, and the FSM returns to IDLE the next cycle.
- in_valid=0 between beats of an open reduction is legal; the accumulator holds.

Optional Feature:
- Macro: VRED_MASK_EN.
- Defined:
  - lanes with in_mask[i]=0 are replaced at stage 0 by the identity of the captured op: all-ones for and, zero for or/xor.
  - An all-zero mask beat leaves the accumulator unchanged, but the first/last semantics still apply.
  - So a fully masked single-beat reduction returns the scalar.
- Undefined:
  - in_mask is unused and all lanes always participate.
  - No identity-mux logic is generated.

Decomposition:
- Shared vALU package:
  - opSel encodings (OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11).
  - An identity-element function.
  - A combine(op,a,b) function that is also used by the accumulator.
- One sub-module: vred_logic_stage.
  - Parametrised by the number of pairs.
  - Registers the pairwise combine plus the sideband.
  - Instantiated log2(LANES) times via generate.

Test Plan (LANES=4, DATA_WIDTH=8 unless noted):
- Single-beat AND: scalar=FF, lanes {F0,3C,FF,F8}, last=1 -> out_vec=30, out_valid exactly at t+3.
- Two-beat XOR: scalar=01, beat1 {01,02,04,08}, beat2 {10,20,40,80}, one idle cycle between beats -> out_vec=FE, one pulse.
- Back-to-back: single-beat OR (scalar=00, {01,02,00,00}) then next cycle single-beat AND (scalar=0F, {FF,FF,FF,0F}) -> 03 then 0F, consecutive pulses.
- rst mid-reduction: assert rst after beat1 of a 2-beat OR, then run a fresh OR (scalar=00, {80,00,00,00}) -> no pulse for the aborted reduction, then 80.
- opSel=00: any data -> out_vec=00.
- VRED_MASK_EN: AND, scalar=FF, lanes {00,FF,FF,FF}, mask=1110 -> FF; mask=0000 -> FF (the scalar); LANES=8 latency -> 4 cycles.
